serializer: RTL and testbench

Parallel-in, serial-out transmitter that takes an N-bit word captured by the datapath registers and shifts it out MSB first on a single wire, one bit per DIV clock cycles. It is the read-out end of the register datapath: upstream logic presents a word and a start strobe, the block reports busy while transmitting and pulses done when the last bit has been held for its full period.

---
 rtl/serializer_pkg.sv | 15 +
 rtl/piso_shift.sv | 32 +++
 rtl/serializer.sv | 121 ++++++++++++
 tb/tb_serializer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared state encoding and counter sizing for the serializer read-out path.
package serializer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

  // Width of a counter spanning 0..v-1; never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// N-bit parallel-load shift register, MSB out, zero fill; load wins over shift.
// o_pre exposes the next bit so the parent can register sout one edge ahead.
module piso_shift
  import serializer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [N-1:0] i_d,
  output logic         o_msb,
  output logic         o_pre
);

  logic [N-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_d;
    end else if (i_shift) begin
      r_sr <= {r_sr[N-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[N-1];
  assign o_pre = r_sr[N-2];

endmodule

// File: rtl/serializer.sv
// Parallel-in serial-out transmitter: word out MSB first, DIV cycles per bit, done pulse after.
// First bit appears the cycle after start is accepted; start is ignored while busy, never queued.
module serializer
  import serializer_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 1
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_start,
  input  logic [N-1:0] i_d,
  output logic         o_sout,
  output logic         o_sval,
  output logic         o_busy,
  output logic         o_done
);

  localparam int DW = cnt_w(DIV);
  localparam int BW = cnt_w(N);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  state_t        r_state;
  logic [DW-1:0] r_div_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          r_sout;
  logic          r_sval;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_nxt;
  logic [DW-1:0] w_div_nxt;
  logic [BW-1:0] w_bit_nxt;
  logic          w_load;
  logic          w_shift;
  logic          w_msb;
  logic          w_pre;
  logic          w_msb_nxt;
  logic          w_div_term;
  logic          w_bit_term;

  piso_shift #(.N(N)) u_piso (
    .i_clk   (i_clk),
    .i_clr   (i_clr),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (i_d),
    .o_msb   (w_msb),
    .o_pre   (w_pre)
  );

  // With DIV=1 the divider never leaves 0, so every cycle is a bit boundary.
  assign w_div_term = (r_div_cnt == DIV_LAST);
  assign w_bit_term = (r_bit_cnt == BIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        if (w_div_term) begin
          w_div_nxt = '0;
          if (w_bit_term) begin
            w_state_nxt = ST_DONE;
            w_bit_nxt   = '0;
          end else begin
            w_shift   = 1'b1;
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        if (i_start) begin
          w_load      = 1'b1;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
    endcase
  end

  // Next MSB of the shift register, so sout can be a flop rather than a decode.
  assign w_msb_nxt = w_load ? i_d[N-1] : (w_shift ? w_pre : w_msb);

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sout    <= 1'b0;
      r_sval    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_sout    <= (w_state_nxt == ST_SHIFT) & w_msb_nxt;
      r_sval    <= (w_state_nxt == ST_SHIFT);
      r_busy    <= (w_state_nxt == ST_SHIFT);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign o_sout = r_sout;
  assign o_sval = r_sval;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: three instances (DIV=1,3,2) share clock and clear.
module tb_serializer;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] start_v;
  logic [7:0] d_a [3];
  logic [2:0] sout_v, sval_v, busy_v, done_v;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  always #5 clk = ~clk;

  serializer #(.N(8), .DIV(1)) u_div1 (
    .i_clk(clk), .i_clr(clr), .i_start(start_v[0]), .i_d(d_a[0]),
    .o_sout(sout_v[0]), .o_sval(sval_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0])
  );

  serializer #(.N(8), .DIV(3)) u_div3 (
    .i_clk(clk), .i_clr(clr), .i_start(start_v[1]), .i_d(d_a[1]),
    .o_sout(sout_v[1]), .o_sval(sval_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1])
  );

  serializer #(.N(8), .DIV(2)) u_div2 (
    .i_clk(clk), .i_clr(clr), .i_start(start_v[2]), .i_d(d_a[2]),
    .o_sout(sout_v[2]), .o_sval(sval_v[2]), .o_busy(busy_v[2]), .o_done(done_v[2])
  );

  // Expected {sout,sval,busy,done} in cycle k+c after start was accepted on edge k.
  function automatic logic [3:0] model(input int div, input logic [7:0] w, input int c);
    if (c >= 1 && c <= 8 * div) return {w[7 - (c - 1) / div], 3'b110};
    if (c == 8 * div + 1) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] obs(input int i);
    return {sout_v[i], sval_v[i], busy_v[i], done_v[i]};
  endfunction

  task automatic test_reset();
    clr     = 1'b0;
    start_v = 3'($urandom);
    for (int i = 0; i < 3; i++) d_a[i] = 8'($urandom);
    #1 clr = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (obs(i) !== 4'b0000) $display("FAIL reset_async inst%0d got %b want 0000", i, obs(i));
      else pass_cnt++;
    end
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk_cnt++;
        if (obs(i) !== 4'b0000) $display("FAIL reset_hold inst%0d got %b want 0000", i, obs(i));
        else pass_cnt++;
      end
      start_v = 3'($urandom);
      for (int i = 0; i < 3; i++) d_a[i] = 8'($urandom);
    end
    @(negedge clk);
    clr     = 1'b0;
    start_v = 3'b000;
  endtask

  task automatic test_div1_a5();
    logic [7:0] got;
    int         busy_n, done_n, done_at;
    got = '0; busy_n = 0; done_n = 0; done_at = -1;
    @(negedge clk);
    d_a[0] = 8'hA5; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0; d_a[0] = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (obs(0) !== model(1, 8'hA5, c)) $display("FAIL a5_cycle c=%0d got %b want %b", c, obs(0), model(1, 8'hA5, c));
      else pass_cnt++;
      if (c <= 8) got = {got[6:0], sout_v[0]};
      if (busy_v[0] === 1'b1) busy_n++;
      if (done_v[0] === 1'b1) begin done_n++; done_at = c; end
    end
    chk_cnt++;
    if (got !== 8'b1010_0101) $display("FAIL a5_bits got %b want 10100101", got);
    else pass_cnt++;
    chk_cnt++;
    if (busy_n != 8) $display("FAIL a5_busy_len got %0d want 8", busy_n);
    else pass_cnt++;
    chk_cnt++;
    if (done_n != 1 || done_at != 9) $display("FAIL a5_done got n=%0d at=%0d want n=1 at=9", done_n, done_at);
    else pass_cnt++;
  endtask

  task automatic test_div3_81();
    int ones_n, done_at, first_zero, last_zero;
    ones_n = 0; done_at = -1; first_zero = -1; last_zero = -1;
    @(negedge clk);
    d_a[1] = 8'h81; start_v[1] = 1'b1;
    @(posedge clk);
    #1 start_v[1] = 1'b0; d_a[1] = 8'h7E;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (obs(1) !== model(3, 8'h81, c)) $display("FAIL div3_cycle c=%0d got %b want %b", c, obs(1), model(3, 8'h81, c));
      else pass_cnt++;
      if (sout_v[1] === 1'b1) ones_n++;
      if (c <= 24 && sout_v[1] === 1'b0) begin
        if (first_zero < 0) first_zero = c;
        last_zero = c;
      end
      if (done_v[1] === 1'b1) done_at = c;
    end
    chk_cnt++;
    if (ones_n != 6 || first_zero != 4 || last_zero != 21)
      $display("FAIL div3_hold got ones=%0d zeros=%0d..%0d want ones=6 zeros=4..21", ones_n, first_zero, last_zero);
    else pass_cnt++;
    chk_cnt++;
    if (done_at != 25) $display("FAIL div3_done got %0d want 25", done_at);
    else pass_cnt++;
  endtask

  task automatic test_start_during_busy();
    int ones_n, done_n, done_at;
    ones_n = 0; done_n = 0; done_at = -1;
    @(negedge clk);
    d_a[0] = 8'hFF; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (obs(0) !== model(1, 8'hFF, c)) $display("FAIL busy_start c=%0d got %b want %b", c, obs(0), model(1, 8'hFF, c));
      else pass_cnt++;
      if (sout_v[0] === 1'b1) ones_n++;
      if (done_v[0] === 1'b1) begin done_n++; done_at = c; end
      start_v[0] = (c >= 4 && c <= 8);
      d_a[0]     = 8'h00;
    end
    chk_cnt++;
    if (ones_n != 8 || done_n != 1 || done_at != 9)
      $display("FAIL busy_summary got ones=%0d dones=%0d at=%0d want 8 1 9", ones_n, done_n, done_at);
    else pass_cnt++;
  endtask

  task automatic test_clr_mid();
    logic [7:0] got;
    got = '0;
    @(negedge clk);
    d_a[2] = 8'hC3; start_v[2] = 1'b1;
    @(posedge clk);
    #1 start_v[2] = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (obs(2) !== model(2, 8'hC3, c)) $display("FAIL clr_pre c=%0d got %b want %b", c, obs(2), model(2, 8'hC3, c));
      else pass_cnt++;
    end
    #1 clr = 1'b1;
    #1;
    chk_cnt++;
    if (obs(2) !== 4'b0000) $display("FAIL clr_immediate got %b want 0000", obs(2));
    else pass_cnt++;
    #1 clr = 1'b0;
    for (int c = 8; c <= 20; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (obs(2) !== 4'b0000) $display("FAIL clr_after c=%0d got %b want 0000", c, obs(2));
      else pass_cnt++;
    end
    d_a[2] = 8'h3C; start_v[2] = 1'b1;
    @(posedge clk);
    #1 start_v[2] = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (obs(2) !== model(2, 8'h3C, c)) $display("FAIL clr_restart c=%0d got %b want %b", c, obs(2), model(2, 8'h3C, c));
      else pass_cnt++;
      if (c <= 16 && (c % 2) == 1) got = {got[6:0], sout_v[2]};
    end
    chk_cnt++;
    if (got !== 8'b0011_1100) $display("FAIL clr_restart_bits got %b want 00111100", got);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int         done_n;
    logic [3:0] exp;
    done_n = 0;
    @(negedge clk);
    d_a[1] = 8'h5A; start_v[1] = 1'b1;
    @(posedge clk);
    #1 d_a[1] = 8'h96;
    for (int c = 1; c <= 54; c++) begin
      @(negedge clk);
      exp = (c <= 26) ? model(3, 8'h5A, c) : model(3, 8'h96, c - 26);
      chk_cnt++;
      if (obs(1) !== exp) $display("FAIL b2b c=%0d got %b want %b", c, obs(1), exp);
      else pass_cnt++;
      if (done_v[1] === 1'b1) done_n++;
      if (c == 27) start_v[1] = 1'b0;
    end
    chk_cnt++;
    if (done_n != 2) $display("FAIL b2b_dones got %0d want 2", done_n);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_div1_a5();
    test_div3_81();
    test_start_during_busy();
    test_clr_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
